// File: rtl/eth_tx_pkt_arbiter.sv
// rtl/eth_tx_pkt_arbiter.sv - packet-granular round-robin arbiter onto one Ethernet TX stream
// Ports:
//   i_clk, i_reset           clock, synchronous active-high reset
//   i_req_valid/sop/eop      per-requester beat handshake and packet framing
//   i_req_data/mod/flags     per-requester beat fields, flattened (requester k = slice k)
//   o_req_ready              per-requester beat accept
//   o_tx_valid/i_tx_ready    merged stream handshake toward the NAP Ethernet wrapper
//   o_tx_sop/eop/data/mod/flags  merged stream fields
//   o_grant                  one-hot current packet owner, 0 between packets
//   o_pkt_cnt                saturating packets-forwarded counter per requester, flattened
//   o_err_sop                sticky per requester: non-SOP beat offered while not owner
module eth_tx_pkt_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 256,
   parameter int MOD_WIDTH  = 5,
   parameter int FLAG_WIDTH = 30,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                            i_clk,
   input  logic                            i_reset,
   input  logic [NUM_REQ-1:0]              i_req_valid,
   output logic [NUM_REQ-1:0]              o_req_ready,
   input  logic [NUM_REQ-1:0]              i_req_sop,
   input  logic [NUM_REQ-1:0]              i_req_eop,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_data,
   input  logic [NUM_REQ*MOD_WIDTH-1:0]    i_req_mod,
   input  logic [NUM_REQ*FLAG_WIDTH-1:0]   i_req_flags,
   output logic                            o_tx_valid,
   input  logic                            i_tx_ready,
   output logic                            o_tx_sop,
   output logic                            o_tx_eop,
   output logic [DATA_WIDTH-1:0]           o_tx_data,
   output logic [MOD_WIDTH-1:0]            o_tx_mod,
   output logic [FLAG_WIDTH-1:0]           o_tx_flags,
   output logic [NUM_REQ-1:0]              o_grant,
   output logic [NUM_REQ*CNT_WIDTH-1:0]    o_pkt_cnt,
   output logic [NUM_REQ-1:0]              o_err_sop
);

   localparam int IDX_W = $clog2(NUM_REQ);

   // The idle cycle doubles as the arbitration cycle: when an eligible SOP is
   // present the winner is registered on that same edge, so exactly one dead
   // cycle separates consecutive packets.
   typedef enum logic {
      S_IDLE = 1'b0,
      S_LOCK = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       grant_q;
   logic [IDX_W-1:0]       rr_ptr_q;
   logic [IDX_W-1:0]       win_idx;
   logic                   win_found;
   logic [CNT_WIDTH-1:0]   cnt_q [NUM_REQ];
   logic [NUM_REQ-1:0]     err_q;
   logic [NUM_REQ-1:0]     err_set;
   logic                   locked;
   logic                   sel_valid;
   logic                   sel_sop;
   logic                   sel_eop;
   logic [DATA_WIDTH-1:0]  sel_data;
   logic [MOD_WIDTH-1:0]   sel_mod;
   logic [FLAG_WIDTH-1:0]  sel_flags;
   logic                   eop_accept;

   assign locked = (state_q == S_LOCK);

   // Round-robin search starting one past the last packet owner.
   always_comb begin
      int               cand;
      logic [IDX_W-1:0] cand_idx;
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand     = (int'(rr_ptr_q) + i) % NUM_REQ;
         cand_idx = IDX_W'(cand);
         if (!win_found && i_req_valid[cand_idx] && i_req_sop[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
   end

   // Zero-latency field mux from the registered owner.
   always_comb begin
      sel_valid = 1'b0;
      sel_sop   = 1'b0;
      sel_eop   = 1'b0;
      sel_data  = '0;
      sel_mod   = '0;
      sel_flags = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant_q == IDX_W'(k)) begin
            sel_valid = i_req_valid[k];
            sel_sop   = i_req_sop[k];
            sel_eop   = i_req_eop[k];
            sel_data  = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
            sel_mod   = i_req_mod[k*MOD_WIDTH +: MOD_WIDTH];
            sel_flags = i_req_flags[k*FLAG_WIDTH +: FLAG_WIDTH];
         end
      end
   end

   always_comb begin
      o_tx_valid = locked && sel_valid && !i_reset;
      o_tx_sop   = o_tx_valid && sel_sop;
      o_tx_eop   = o_tx_valid && sel_eop;
      o_tx_data  = sel_data;
      o_tx_mod   = sel_mod;
      o_tx_flags = sel_flags;
      eop_accept = o_tx_valid && i_tx_ready && sel_eop;
   end

   // Stray non-SOP beats are drained only while no packet is locked; during a
   // packet a non-owner's stray beat is flagged but left pending.
   always_comb begin
      o_req_ready = '0;
      err_set     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (locked) begin
            if (grant_q == IDX_W'(k)) begin
               o_req_ready[k] = i_tx_ready;
            end else begin
               err_set[k] = i_req_valid[k] && !i_req_sop[k];
            end
         end else begin
            o_req_ready[k] = i_req_valid[k] && !i_req_sop[k];
            err_set[k]     = i_req_valid[k] && !i_req_sop[k];
         end
      end
      if (i_reset) begin
         o_req_ready = '0;
      end
   end

   always_comb begin
      o_grant = '0;
      if (locked) begin
         o_grant = NUM_REQ'(1) << grant_q;
      end
   end

   always_comb begin
      o_pkt_cnt = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         o_pkt_cnt[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q[k];
      end
   end

   assign o_err_sop = err_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (win_found)  state_d = S_LOCK;
         S_LOCK:  if (eop_accept) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q  <= S_IDLE;
         grant_q  <= '0;
         rr_ptr_q <= IDX_W'(NUM_REQ - 1);
         err_q    <= '0;
         for (int k = 0; k < NUM_REQ; k++) begin
            cnt_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         err_q   <= err_q | err_set;
         if (!locked && win_found) begin
            grant_q <= win_idx;
         end
         if (eop_accept) begin
            rr_ptr_q <= grant_q;
            if (cnt_q[grant_q] != {CNT_WIDTH{1'b1}}) begin
               cnt_q[grant_q] <= cnt_q[grant_q] + CNT_WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_eth_tx_pkt_arbiter.sv
// tb/tb_eth_tx_pkt_arbiter.sv - randomized self-checking bench for eth_tx_pkt_arbiter
module tb_eth_tx_pkt_arbiter;

   logic          clk = 1'b0;
   logic          reset;
   logic [3:0]    req_valid, req_sop, req_eop;
   logic [1023:0] req_data;
   logic [19:0]   req_mod;
   logic [119:0]  req_flags;
   logic          tx_ready;

   logic [3:0]    req_ready, grant, err_sop;
   logic          tx_valid, tx_sop, tx_eop;
   logic [255:0]  tx_data;
   logic [4:0]    tx_mod;
   logic [29:0]   tx_flags;
   logic [63:0]   pkt_cnt;

   logic [3:0]    req_ready_s, grant_s, err_sop_s;
   logic          tx_valid_s, tx_sop_s, tx_eop_s;
   logic [255:0]  tx_data_s;
   logic [4:0]    tx_mod_s;
   logic [29:0]   tx_flags_s;
   logic [7:0]    pkt_cnt_s;

   always #5 clk = ~clk;

   eth_tx_pkt_arbiter dut (
      .i_clk(clk), .i_reset(reset),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_sop(req_sop), .i_req_eop(req_eop),
      .i_req_data(req_data), .i_req_mod(req_mod), .i_req_flags(req_flags),
      .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
      .o_tx_sop(tx_sop), .o_tx_eop(tx_eop),
      .o_tx_data(tx_data), .o_tx_mod(tx_mod), .o_tx_flags(tx_flags),
      .o_grant(grant), .o_pkt_cnt(pkt_cnt), .o_err_sop(err_sop)
   );

   // Same stimulus, 2-bit counters so saturation is reached quickly.
   eth_tx_pkt_arbiter #(.CNT_WIDTH(2)) dut_s (
      .i_clk(clk), .i_reset(reset),
      .i_req_valid(req_valid), .o_req_ready(req_ready_s),
      .i_req_sop(req_sop), .i_req_eop(req_eop),
      .i_req_data(req_data), .i_req_mod(req_mod), .i_req_flags(req_flags),
      .o_tx_valid(tx_valid_s), .i_tx_ready(tx_ready),
      .o_tx_sop(tx_sop_s), .o_tx_eop(tx_eop_s),
      .o_tx_data(tx_data_s), .o_tx_mod(tx_mod_s), .o_tx_flags(tx_flags_s),
      .o_grant(grant_s), .o_pkt_cnt(pkt_cnt_s), .o_err_sop(err_sop_s)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: packet owner (-1 = none), last owner, counts, error flags.
   int         m_owner;
   int         m_last;
   int         m_cnt [4];
   logic [3:0] m_err;

   // Per-requester traffic source.
   bit d_busy [4];
   bit d_stray [4];
   int d_len [4];
   int d_idx [4];

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_last  = 3;
      m_err   = '0;
      for (int p = 0; p < 4; p++) begin
         m_cnt[p]  = 0;
         d_busy[p] = 1'b0;
      end
   endtask

   task automatic step(input int p_start, input int max_len, input int p_bubble,
                       input int p_stray, input int p_ready, input bit do_rst);
      logic [3:0]   exp_ready;
      logic [3:0]   exp_grant;
      logic         exp_tv, exp_sop, exp_eop;
      logic [255:0] exp_data;
      logic [34:0]  exp_fields;
      int           r, c, o;
      @(negedge clk);
      for (int p = 0; p < 4; p++) begin
         if (!d_busy[p]) begin
            r = $urandom_range(0, 99);
            if (r < p_stray) begin
               d_busy[p] = 1'b1; d_stray[p] = 1'b1; d_len[p] = 1; d_idx[p] = 0;
            end else if (r < p_stray + p_start) begin
               d_busy[p] = 1'b1; d_stray[p] = 1'b0; d_idx[p] = 0;
               d_len[p] = $urandom_range(1, max_len);
            end
         end
         req_valid[p] = d_busy[p] && ($urandom_range(0, 99) >= p_bubble);
         if (d_busy[p]) begin
            req_sop[p] = !d_stray[p] && (d_idx[p] == 0);
            req_eop[p] = d_stray[p] ? 1'($urandom_range(0, 1)) : (d_idx[p] == d_len[p] - 1);
         end else begin
            req_sop[p] = 1'($urandom_range(0, 1));
            req_eop[p] = 1'($urandom_range(0, 1));
         end
         for (int w = 0; w < 8; w++) req_data[p*256 + w*32 +: 32] = $urandom;
         req_mod[p*5 +: 5]     = 5'($urandom);
         req_flags[p*30 +: 30] = 30'($urandom);
      end
      tx_ready = ($urandom_range(0, 99) < p_ready);
      reset    = do_rst;
      #1;

      exp_grant  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
      exp_ready  = '0;
      exp_tv     = 1'b0;
      exp_sop    = 1'b0;
      exp_eop    = 1'b0;
      exp_data   = '0;
      exp_fields = '0;
      if (!do_rst) begin
         if (m_owner >= 0) begin
            o = m_owner;
            exp_ready[o] = tx_ready;
            exp_tv       = req_valid[o];
            if (exp_tv) begin
               exp_sop    = req_sop[o];
               exp_eop    = req_eop[o];
               exp_data   = req_data[o*256 +: 256];
               exp_fields = {req_mod[o*5 +: 5], req_flags[o*30 +: 30]};
            end
         end else begin
            exp_ready = req_valid & ~req_sop;
         end
      end

      check("grant", grant, exp_grant);
      check("grant_s", grant_s, exp_grant);
      check("req_ready", req_ready, exp_ready);
      check("req_ready_s", req_ready_s, exp_ready);
      check("tx_ctl", {tx_valid, tx_sop, tx_eop}, {exp_tv, exp_sop, exp_eop});
      check("tx_ctl_s", {tx_valid_s, tx_sop_s, tx_eop_s}, {exp_tv, exp_sop, exp_eop});
      if (exp_tv) begin
         check("tx_data", tx_data, exp_data);
         check("tx_data_s", tx_data_s, exp_data);
         check("tx_mod_flags", {tx_mod, tx_flags}, exp_fields);
         check("tx_mod_flags_s", {tx_mod_s, tx_flags_s}, exp_fields);
      end
      check("err_sop", err_sop, m_err);
      check("err_sop_s", err_sop_s, m_err);
      for (int p = 0; p < 4; p++) begin
         check("pkt_cnt", pkt_cnt[p*16 +: 16], 256'(m_cnt[p]));
         check("pkt_cnt_sat", pkt_cnt_s[p*2 +: 2], 256'((m_cnt[p] > 3) ? 3 : m_cnt[p]));
      end

      if (do_rst) begin
         model_reset();
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (req_valid[k] && exp_ready[k]) begin
               d_idx[k]++;
               if (d_stray[k] || d_idx[k] == d_len[k]) d_busy[k] = 1'b0;
            end
            if (req_valid[k] && !req_sop[k] && m_owner != k) m_err[k] = 1'b1;
         end
         if (m_owner < 0) begin
            for (int i = 1; i <= 4; i++) begin
               c = (m_last + i) % 4;
               if (m_owner < 0 && req_valid[c] && req_sop[c]) m_owner = c;
            end
         end else if (req_valid[m_owner] && tx_ready && req_eop[m_owner]) begin
            if (m_cnt[m_owner] < 65535) m_cnt[m_owner]++;
            m_last  = m_owner;
            m_owner = -1;
         end
      end
   endtask

   initial begin
      bit did_rst;
      bit rst_now;
      reset     = 1'b1;
      req_valid = '0;
      req_sop   = '0;
      req_eop   = '0;
      req_data  = '0;
      req_mod   = '0;
      req_flags = '0;
      tx_ready  = 1'b1;
      did_rst   = 1'b0;
      model_reset();

      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_grant", grant, 0);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_err_sop", err_sop, 0);
      check("rst_pkt_cnt", pkt_cnt, 0);
      check("rst_tx_sop_eop", {tx_sop, tx_eop}, 0);
      reset = 1'b0;

      // Everyone streams single-beat packets: strict rotation, one gap cycle each.
      for (int c = 0; c < 40; c++) step(100, 1, 0, 0, 100, 1'b0);
      // Multi-beat packets under heavy backpressure.
      for (int c = 0; c < 250; c++) step(40, 5, 0, 0, 50, 1'b0);
      // Fully random traffic with bubbles, stray beats and one mid-packet reset.
      for (int c = 0; c < 1500; c++) begin
         rst_now = 1'b0;
         if (!did_rst && c >= 600 && m_owner >= 0) begin
            if (d_busy[m_owner] && d_idx[m_owner] >= 1) rst_now = 1'b1;
         end
         if (rst_now) did_rst = 1'b1;
         step(30, 5, 20, 3, 70, rst_now);
      end

      reset = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
